// File: rtl/obstacle_pkg.sv
// Shared obstacle types and word layout; imported by obstacle_stream, game_logic and the renderer.
package obstacle_pkg;

    localparam int NUM_LANES = 3;
    localparam int DEPTH_W   = 11;

    typedef enum logic [2:0] {
        ObsNone      = 3'b000,
        ObsLow       = 3'b001,
        ObsHigh      = 3'b010,
        ObsMiddle    = 3'b011,
        ObsTrain     = 3'b100,
        ObsRamp      = 3'b101,
        ObsMovingCar = 3'b110
    } obstacle_t;

    typedef logic [1:0] lane_t;

    typedef struct packed {
        logic [DEPTH_W-1:0] depth;
        lane_t              lane;
        obstacle_t          kind;
    } obstacle_word_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois form, taps 16,14,13,11, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; advances STEPS positions per step pulse, load overrides step.
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned STEPS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed_value,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] adv;

    always_comb begin
        adv = state_q;
        for (int i = 0; i < int'(STEPS); i++) begin
            adv = lfsr_next(adv);
        end
        state_d = state_q;
        if (load) begin
            state_d = seed_value;
        end else if (step) begin
            state_d = adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/obstacle_stream.sv
// Scrolling obstacle window and per-frame word streamer.
// Define MOVING_CAR_EN to let LFSR code 110 produce moving-car cells.
module obstacle_stream
    import obstacle_pkg::*;
#(
    parameter int unsigned HALF_BLOCK_LENGTH = 64,
    parameter int unsigned ROWS              = 8,
    parameter int unsigned GRACE_ROWS        = 3,
    parameter int unsigned TRAIN_MAX         = 6,
    parameter logic [15:0] SEED              = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic [15:0] player_score,
    input  logic        obstacle_ready,
    output logic        obstacle_valid,
    output logic [15:0] obstacle,
    output logic        firstrow,
    output logic        frame_done,
    output logic        overrun
);

    localparam int LOG2_HBL = $clog2(HALF_BLOCK_LENGTH);
    localparam int ROWS_I   = int'(ROWS);
    localparam int CELLS    = ROWS_I * NUM_LANES;
    localparam int CELL_W   = $clog2(CELLS + 1);
    localparam int ROW_W    = $clog2(ROWS_I);
    localparam int SHIFT_W  = $clog2(ROWS_I + 1);
    localparam int RUN_W    = $clog2(TRAIN_MAX + 2);
    localparam int GRACE_W  = $clog2(GRACE_ROWS + 2);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StScroll = 2'd1;
    localparam logic [1:0] StEmit   = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]          state_q;
    obstacle_t           cells_q [ROWS_I][NUM_LANES];
    logic [RUN_W-1:0]    run_q   [NUM_LANES];
    logic [RUN_W-1:0]    run_d   [NUM_LANES];
    logic [GRACE_W-1:0]  grace_q;
    logic [15:0]         prev_blk_q;
    logic [LOG2_HBL-1:0] prog_q;
    logic [SHIFT_W-1:0]  shift_cnt_q;
    logic [CELL_W-1:0]   pos_q;
    logic                overrun_q;

    logic [15:0]         blk;
    logic [15:0]         blk_diff;
    logic [SHIFT_W-1:0]  shift_req;
    logic                gen_row;
    logic                in_grace;
    logic [15:0]         lfsr_state;
    logic [15:0]         s [NUM_LANES+1];
    lane_t               lane_pick;
    obstacle_t           new_row [NUM_LANES];
    logic                found;
    logic                more;
    logic [CELL_W-1:0]   hit_idx;
    logic [ROW_W-1:0]    hit_row;
    lane_t               hit_lane;
    obstacle_word_t      word;

    assign blk       = player_score >> LOG2_HBL;
    assign blk_diff  = blk - prev_blk_q;
    assign shift_req = (blk_diff > 16'(ROWS_I)) ? SHIFT_W'(ROWS_I) : SHIFT_W'(blk_diff);
    assign gen_row   = (state_q == StScroll) && !new_frame && (shift_cnt_q != '0);
    assign in_grace  = grace_q < GRACE_W'(GRACE_ROWS);

    lfsr16 #(
        .SEED  (SEED),
        .STEPS (NUM_LANES)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step       (gen_row),
        .load       (1'b0),
        .seed_value (SEED),
        .state      (lfsr_state)
    );

    // Each lane draws its code from the LFSR state after its own step.
    always_comb begin
        s[0] = lfsr_state;
        for (int l = 0; l < NUM_LANES; l++) begin
            s[l+1] = lfsr_next(s[l]);
        end
        lane_pick = lane_t'(s[NUM_LANES] % 16'(NUM_LANES));
        for (int l = 0; l < NUM_LANES; l++) begin
            new_row[l] = ObsNone;
            case (s[l+1][2:0])
                3'b111: new_row[l] = ObsNone;
`ifdef MOVING_CAR_EN
                3'b110: new_row[l] = ObsMovingCar;
`else
                3'b110: new_row[l] = ObsNone;
`endif
                3'b100: begin
                    if ((cells_q[ROWS_I-1][l] == ObsTrain || cells_q[ROWS_I-1][l] == ObsRamp)
                        && run_q[l] < RUN_W'(TRAIN_MAX)) begin
                        new_row[l] = ObsTrain;
                    end
                end
                default: new_row[l] = obstacle_t'(s[l+1][2:0]);
            endcase
        end
        if (new_row[0] == ObsTrain && new_row[1] == ObsTrain && new_row[2] == ObsTrain) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_pick == lane_t'(l)) begin
                    new_row[l] = ObsNone;
                end
            end
        end
        if (in_grace) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                new_row[l] = ObsNone;
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            run_d[l] = (new_row[l] == ObsTrain) ? run_q[l] + RUN_W'(1) : '0;
        end
    end

    // Lookahead to the first non-empty cell at or after pos_q, and whether another follows it.
    always_comb begin
        found    = 1'b0;
        more     = 1'b0;
        hit_idx  = '0;
        hit_row  = '0;
        hit_lane = '0;
        for (int r = 0; r < ROWS_I; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (cells_q[r][l] != ObsNone && CELL_W'(r * NUM_LANES + l) >= pos_q) begin
                    if (!found) begin
                        found    = 1'b1;
                        hit_idx  = CELL_W'(r * NUM_LANES + l);
                        hit_row  = ROW_W'(r);
                        hit_lane = lane_t'(l);
                    end else begin
                        more = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grace_q <= '0;
            for (int r = 0; r < ROWS_I; r++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    cells_q[r][l] <= ObsNone;
                end
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                run_q[l] <= '0;
            end
        end else if (gen_row) begin
            for (int r = 0; r < ROWS_I - 1; r++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    cells_q[r][l] <= cells_q[r+1][l];
                end
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                cells_q[ROWS_I-1][l] <= new_row[l];
                run_q[l]             <= run_d[l];
            end
            if (in_grace) begin
                grace_q <= grace_q + GRACE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_blk_q  <= '0;
            prog_q      <= '0;
            shift_cnt_q <= '0;
            pos_q       <= '0;
            overrun_q   <= 1'b0;
        end else if (new_frame) begin
            // A new frame always wins, even mid-emission.
            state_q     <= StScroll;
            shift_cnt_q <= shift_req;
            prev_blk_q  <= blk;
            prog_q      <= player_score[LOG2_HBL-1:0];
            pos_q       <= '0;
            if (state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StScroll: begin
                    if (shift_cnt_q != '0) begin
                        shift_cnt_q <= shift_cnt_q - SHIFT_W'(1);
                    end
                    if (shift_cnt_q <= SHIFT_W'(1)) begin
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    if (!found) begin
                        state_q <= StDone;
                    end else if (obstacle_ready) begin
                        pos_q <= hit_idx + CELL_W'(1);
                        if (!more) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        word.depth = DEPTH_W'(hit_row) * DEPTH_W'(HALF_BLOCK_LENGTH)
                   + DEPTH_W'(HALF_BLOCK_LENGTH - 1) - DEPTH_W'(prog_q);
        word.lane  = hit_lane;
        word.kind  = cells_q[hit_row][hit_lane];
    end

    assign obstacle_valid = (state_q == StEmit) && found;
    assign obstacle       = obstacle_valid ? word : '0;
    assign firstrow       = obstacle_valid && (hit_row == '0);
    assign frame_done     = (state_q == StDone);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_obstacle_stream.sv
// Scoreboard bench for obstacle_stream: a behavioural window/LFSR model predicts each frame's words.
module tb_obstacle_stream;

    localparam int HBL   = 64;
    localparam int ROWS  = 8;
    localparam int GRACE = 3;
    localparam int TMAX  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_frame;
    logic [15:0] player_score;
    logic        obstacle_ready;
    logic        obstacle_valid;
    logic [15:0] obstacle;
    logic        firstrow;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [2:0]  m_cells [ROWS][3];
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    int          m_grace;
    int          m_run [3];
    int          m_prog;
    logic [16:0] exp_q [$];

    logic [2:0]  obs [ROWS][3];
    logic        soak;
    int          o_run [3];
    int          viol;
    int          done_at;

    always #5 clk = ~clk;

    obstacle_stream #(
        .HALF_BLOCK_LENGTH (HBL),
        .ROWS              (ROWS),
        .GRACE_ROWS        (GRACE),
        .TRAIN_MAX         (TMAX),
        .SEED              (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_frame      (new_frame),
        .player_score   (player_score),
        .obstacle_ready (obstacle_ready),
        .obstacle_valid (obstacle_valid),
        .obstacle       (obstacle),
        .firstrow       (firstrow),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] v);
        logic lsb;
        lsb = v[0];
        v = v >> 1;
        if (lsb) v = v ^ 16'hB400;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < 3; l++) m_cells[r][l] = 3'b000;
        for (int l = 0; l < 3; l++) m_run[l] = 0;
        m_lfsr  = 16'hACE1;
        m_prev  = 16'd0;
        m_grace = 0;
        m_prog  = 0;
        exp_q.delete();
    endtask

    task automatic model_gen_row();
        logic [2:0] nr [3];
        logic [2:0] c;
        for (int l = 0; l < 3; l++) begin
            m_lfsr = adv(m_lfsr);
            c = m_lfsr[2:0];
            if (c == 3'b111) c = 3'b000;
`ifndef MOVING_CAR_EN
            if (c == 3'b110) c = 3'b000;
`endif
            if (c == 3'b100 && !((m_cells[ROWS-1][l] == 3'b101 || m_cells[ROWS-1][l] == 3'b100)
                                 && m_run[l] < TMAX)) c = 3'b000;
            nr[l] = c;
        end
        if (nr[0] == 3'b100 && nr[1] == 3'b100 && nr[2] == 3'b100) nr[int'(m_lfsr % 16'd3)] = 3'b000;
        if (m_grace < GRACE) begin
            for (int l = 0; l < 3; l++) nr[l] = 3'b000;
            m_grace++;
        end
        for (int l = 0; l < 3; l++) m_run[l] = (nr[l] == 3'b100) ? m_run[l] + 1 : 0;
        for (int r = 0; r < ROWS - 1; r++)
            for (int l = 0; l < 3; l++) m_cells[r][l] = m_cells[r+1][l];
        for (int l = 0; l < 3; l++) m_cells[ROWS-1][l] = nr[l];
    endtask

    task automatic model_frame(input logic [15:0] score);
        logic [15:0] blk;
        logic [15:0] d;
        int n;
        blk = score >> 6;
        d   = blk - m_prev;
        n   = (d > 16'(ROWS)) ? ROWS : int'(d);
        repeat (n) model_gen_row();
        m_prev = blk;
        m_prog = int'(score[5:0]);
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < 3; l++)
                if (m_cells[r][l] != 3'b000)
                    exp_q.push_back({r == 0, 11'(r * HBL + HBL - 1 - m_prog), 2'(l), m_cells[r][l]});
    endtask

    task automatic clear_obs();
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < 3; l++) obs[r][l] = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1; new_frame = 1'b0; obstacle_ready = 1'b0; player_score = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one frame and scoreboards every accepted word until frame_done.
    task automatic run_frame(input logic [15:0] score, input int stall_at,
                             input int interrupt_at, input logic [15:0] score2);
        int n;
        int accepted;
        int stall_left;
        logic got_done;
        logic [16:0] held;
        model_frame(score);
        clear_obs();
        player_score = score; new_frame = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0;
        n = 0; accepted = 0; stall_left = 10; got_done = 1'b0; held = '0; done_at = -1;
        while (!got_done && n < 400) begin
            if (frame_done) begin
                got_done = 1'b1;
                done_at  = n;
                continue;
            end
            obstacle_ready = 1'b1;
            if (obstacle_valid && accepted == interrupt_at) begin
                obstacle_ready = 1'b0;
                player_score = score2; new_frame = 1'b1;
                model_frame(score2);
                clear_obs();
                @(posedge clk); #1;
                new_frame = 1'b0; n++;
                check_eq("drop_valid", 32'(obstacle_valid), 32'(0));
                check_eq("overrun_set", 32'(overrun), 32'(1));
                accepted = 0; interrupt_at = -1;
                continue;
            end
            if (obstacle_valid && accepted == stall_at && stall_left > 0) begin
                if (stall_left == 10) held = {firstrow, obstacle};
                else check_eq("stall_hold", 32'({obstacle_valid, firstrow, obstacle}), 32'({1'b1, held}));
                obstacle_ready = 1'b0;
                stall_left--;
            end
            if (obstacle_valid && obstacle_ready) begin
                if (exp_q.size() == 0) check_eq("extra_word", 32'({firstrow, obstacle}), 32'h1ffff);
                else check_eq("word", 32'({firstrow, obstacle}), 32'(exp_q.pop_front()));
                obs[int'(obstacle[15:5]) / HBL][int'(obstacle[4:3])] = obstacle[2:0];
                accepted++;
            end
            @(posedge clk); #1;
            n++;
        end
        obstacle_ready = 1'b0;
        check_eq("frame_done_seen", 32'(got_done), 32'(1));
        check_eq("words_left", 32'(exp_q.size()), 32'(0));
        if (stall_at >= 0 && stall_left < 10) check_eq("stall_count", 32'(stall_left), 32'(0));
        if (soak) begin
            for (int r = 0; r < ROWS; r++) begin
                if (obs[r][0] == 3'b100 && obs[r][1] == 3'b100 && obs[r][2] == 3'b100) viol++;
                for (int l = 0; l < 3; l++) begin
`ifndef MOVING_CAR_EN
                    if (obs[r][l] == 3'b110) viol++;
`endif
                    o_run[l] = (obs[r][l] == 3'b100) ? o_run[l] + 1 : 0;
                    if (o_run[l] > TMAX) viol++;
                end
            end
        end
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(frame_done), 32'(0));
    endtask

    initial begin
        logic [15:0] base;
        int n;
        soak = 1'b0; viol = 0;
        for (int l = 0; l < 3; l++) o_run[l] = 0;

        do_reset();
        check_eq("rst_valid", 32'(obstacle_valid), 32'(0));
        check_eq("rst_obstacle", 32'(obstacle), 32'(0));
        check_eq("rst_firstrow", 32'(firstrow), 32'(0));
        check_eq("rst_frame_done", 32'(frame_done), 32'(0));
        check_eq("rst_overrun", 32'(overrun), 32'(0));

        // Empty window: DONE two cycles after SCROLL.
        run_frame(16'd0, -1, -1, 16'd0);
        check_eq("empty_done_lat", 32'(done_at), 32'(2));

        // Grace rows enter the window empty.
        for (int f = 1; f <= GRACE; f++) run_frame(16'(f * 64), -1, -1, 16'd0);
        check_eq("grace_no_overrun", 32'(overrun), 32'(0));

        // Single-row scrolls with varying progress within the row.
        base = 16'(GRACE * 64);
        for (int f = 0; f < 12; f++) begin
            base = base + 16'd64;
            run_frame(base | 16'($urandom_range(0, 63)), -1, -1, 16'd0);
        end
        check_eq("step_no_overrun", 32'(overrun), 32'(0));

        // Back-pressure mid-emission.
        base = base + 16'd64;
        run_frame(base | 16'd17, 1, -1, 16'd0);

        // New frame during EMIT restarts emission from row 0.
        base = base + 16'd64;
        run_frame(base, -1, 2, base + 16'd64 + 16'd5);
        base = base + 16'd64;
        base = base + 16'd128;
        run_frame(base, -1, -1, 16'd0);
        check_eq("overrun_sticky", 32'(overrun), 32'(1));

        // Reset while words are being emitted.
        base = base + 16'd64;
        model_frame(base);
        player_score = base; new_frame = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0;
        n = 0;
        while (!obstacle_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_mid_seen_valid", 32'(obstacle_valid), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_valid", 32'(obstacle_valid), 32'(0));
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_eq("rst_clears_overrun", 32'(overrun), 32'(0));
        run_frame(16'd0, -1, -1, 16'd0);

        // Score jump 0 -> 1000 is clamped to a full-window regeneration.
        run_frame(16'd1000, -1, -1, 16'd0);

        // Long run of full-window scrolls, tracking emitted rows across frames.
        soak = 1'b1;
        base = 16'd1024;
        for (int f = 0; f < 1250; f++) begin
            base = base + 16'd512;
            run_frame(base | 16'($urandom_range(0, 63)), -1, -1, 16'd0);
        end
        soak = 1'b0;
        check_eq("soak_invariants", 32'(viol), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
